// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// entry_t describes one in-flight register write: valid bit, destination
// address (zero-extended to ADDR_W_MAX) and the first stage whose output
// holds the result.
package pipe_hazard_scoreboard_pkg;

  localparam int unsigned ADDR_W_MAX = 8;  // widest supported ADDR_W
  localparam int unsigned STAGE_W    = 4;  // holds stage numbers 0..8

  localparam logic [STAGE_W-1:0]    FWD_RF    = '0;  // select: register file
  localparam logic [ADDR_W_MAX-1:0] ADDR_ZERO = '0;  // hardwired-zero register

  typedef struct packed {
    logic                  vld;
    logic [ADDR_W_MAX-1:0] waddr;
    logic [STAGE_W-1:0]    rdy;
  } entry_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_hazard_match.sv
// Combinational source-operand match against the in-flight write entries.
// Ports:
//   entries  in  DEPTH entries, index 0 = stage 1 (EX)
//   addr     in  source register address
//   use_en   in  instruction actually reads this source
//   hit      out some valid entry writes addr (addr != 0)
//   stage    out stage number (1..DEPTH) of the youngest matching entry
//   ready    out that entry's result is already available at its stage
module pipe_hazard_scoreboard_hazard_match
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 5
) (
  input  entry_t [DEPTH-1:0]  entries,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                use_en,
  output logic                hit,
  output logic [STAGE_W-1:0]  stage,
  output logic                ready
);

  logic [ADDR_W_MAX-1:0] key;
  logic [STAGE_W-1:0]    rdy_sel;

  // Scan oldest to youngest so the youngest (lowest stage) match is kept last.
  always_comb begin
    hit     = 1'b0;
    stage   = FWD_RF;
    rdy_sel = '0;
    key     = ADDR_W_MAX'(addr);
    if (use_en && (key != ADDR_ZERO)) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries[i].vld && (entries[i].waddr == key)) begin
          hit     = 1'b1;
          stage   = STAGE_W'(i + 1);
          rdy_sel = entries[i].rdy;
        end
      end
    end
    ready = hit && (stage >= rdy_sel);
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Register-write scoreboard for the post-decode pipeline: resolves ID-stage
// operands to a forwarded stage result or the register file, and stalls
// when a needed result is not produced yet.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid/id_rs/id_rt       ID instruction and its source addresses
//   id_use_rs/id_use_rt        source read enables
//   id_wr_en/id_wr_addr        destination write enable and address
//   id_is_load                 result comes from memory (ready at LOAD_STAGE)
//   flush                      kill the ID instruction
//   rf_a/rf_b                  register file read data
//   stage_res                  per-stage results, stage k at [k*DATA_W-1 -: DATA_W]
//   opnd_a/opnd_b              resolved operands (combinational)
//   fwd_sel_a/fwd_sel_b        0 = register file, k = stage k (combinational)
//   stall                      hold PC and IF/ID, insert bubble (combinational)
//   stall_cnt                  saturating stall-cycle counter (registered)
// ADDR_W must not exceed ADDR_W_MAX; DEPTH must be 2..8.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [ADDR_W-1:0]       id_rs,
  input  logic [ADDR_W-1:0]       id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_wr_en,
  input  logic [ADDR_W-1:0]       id_wr_addr,
  input  logic                    id_is_load,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       rf_a,
  input  logic [DATA_W-1:0]       rf_b,
  input  logic [DEPTH*DATA_W-1:0] stage_res,
  output logic [DATA_W-1:0]       opnd_a,
  output logic [DATA_W-1:0]       opnd_b,
  output logic [3:0]              fwd_sel_a,
  output logic [3:0]              fwd_sel_b,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [STAGE_W-1:0] RDY_ALU  = STAGE_W'(1);
  localparam logic [STAGE_W-1:0] RDY_LOAD = STAGE_W'(LOAD_STAGE);

  entry_t [DEPTH-1:0] entries;
  entry_t             entry_in;

  logic               hit_a, hit_b, ready_a, ready_b;
  logic [STAGE_W-1:0] stage_a, stage_b;

  pipe_hazard_scoreboard_hazard_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_a (
    .entries (entries),
    .addr    (id_rs),
    .use_en  (id_use_rs),
    .hit     (hit_a),
    .stage   (stage_a),
    .ready   (ready_a)
  );

  pipe_hazard_scoreboard_hazard_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_b (
    .entries (entries),
    .addr    (id_rt),
    .use_en  (id_use_rt),
    .hit     (hit_b),
    .stage   (stage_b),
    .ready   (ready_b)
  );

  // Stall only for a live instruction whose needed result is not yet produced.
  always_comb begin
    stall = id_valid && !flush && ((hit_a && !ready_a) || (hit_b && !ready_b));
  end

  // New stage-1 entry: a bubble unless a real, non-r0 writer leaves ID.
  always_comb begin
    entry_in = '0;
    if (id_valid && id_wr_en && (ADDR_W_MAX'(id_wr_addr) != ADDR_ZERO) && !stall && !flush) begin
      entry_in.vld   = 1'b1;
      entry_in.waddr = ADDR_W_MAX'(id_wr_addr);
      entry_in.rdy   = id_is_load ? RDY_LOAD : RDY_ALU;
    end
  end

  // Scoreboard shifts every cycle, including stall cycles, so stalls self-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else begin
      entries <= {entries[DEPTH-2:0], entry_in};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Forward select and operand mux; a not-ready match reads the register file.
  always_comb begin
    fwd_sel_a = (hit_a && ready_a) ? stage_a : FWD_RF;
    fwd_sel_b = (hit_b && ready_b) ? stage_b : FWD_RF;
    opnd_a    = rf_a;
    opnd_b    = rf_b;
    for (int k = 1; k <= DEPTH; k++) begin
      if (fwd_sel_a == STAGE_W'(k)) opnd_a = stage_res[k*DATA_W-1 -: DATA_W];
      if (fwd_sel_b == STAGE_W'(k)) opnd_b = stage_res[k*DATA_W-1 -: DATA_W];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench: a default instance (DEPTH=3, LOAD_STAGE=2) and a
// deeper one (DEPTH=5, LOAD_STAGE=4) share the ID-side inputs. A directed
// vector table, hand-written reset / load-use sequences and a random phase
// are checked against a stage-array reference model.
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic [31:0] rf_a, rf_b;
  logic [3*32-1:0] sres0;
  logic [5*32-1:0] sres1;

  logic [31:0] opnd_a0, opnd_b0, opnd_a1, opnd_b1;
  logic [3:0]  fwd_sel_a0, fwd_sel_b0, fwd_sel_a1, fwd_sel_b1;
  logic        stall0, stall1;
  logic [15:0] stall_cnt0, stall_cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .rf_a(rf_a), .rf_b(rf_b), .stage_res(sres0), .opnd_a(opnd_a0), .opnd_b(opnd_b0),
    .fwd_sel_a(fwd_sel_a0), .fwd_sel_b(fwd_sel_b0), .stall(stall0), .stall_cnt(stall_cnt0)
  );

  pipe_hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .rf_a(rf_a), .rf_b(rf_b), .stage_res(sres1), .opnd_a(opnd_a1), .opnd_b(opnd_b1),
    .fwd_sel_a(fwd_sel_a1), .fwd_sel_b(fwd_sel_b1), .stall(stall1), .stall_cnt(stall_cnt1)
  );

  // Reference model: per instance, what is in flight at each stage 1..DEPTH.
  int md[2]  = '{3, 5};
  int mls[2] = '{2, 4};
  bit mv[2][9];
  int ma[2][9];
  int mr[2][9];
  int mcnt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slice(input int u, input int k);
    if (u == 0) return sres0[(k-1)*32 +: 32];
    return sres1[(k-1)*32 +: 32];
  endfunction

  // Youngest in-flight writer of addr decides: forward if produced, else stall.
  function automatic void resolve(input int u, input int addr, input bit use_en,
                                  output int sel, output bit req);
    sel = 0;
    req = 1'b0;
    if (!use_en || addr == 0) return;
    for (int k = 1; k <= md[u]; k++) begin
      if (mv[u][k] && ma[u][k] == addr) begin
        if (k >= mr[u][k]) sel = k;
        else req = 1'b1;
        return;
      end
    end
  endfunction

  function automatic bit model_stall(input int u);
    int sa, sb;
    bit ra, rb;
    resolve(u, int'(id_rs), id_use_rs, sa, ra);
    resolve(u, int'(id_rt), id_use_rt, sb, rb);
    return id_valid && !flush && (ra || rb);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mcnt[u] = 0;
      for (int k = 0; k < 9; k++) mv[u][k] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int u = 0; u < 2; u++) begin
      bit st;
      st = model_stall(u);
      for (int k = md[u]; k >= 2; k--) begin
        mv[u][k] = mv[u][k-1];
        ma[u][k] = ma[u][k-1];
        mr[u][k] = mr[u][k-1];
      end
      mv[u][1] = id_valid && id_wr_en && (id_wr_addr != 5'd0) && !st && !flush;
      ma[u][1] = int'(id_wr_addr);
      mr[u][1] = id_is_load ? mls[u] : 1;
      if (st && mcnt[u] < 65535) mcnt[u]++;
    end
  endtask

  // Compare both instances against the model at the current inputs.
  task automatic check_now(input string tag);
    for (int u = 0; u < 2; u++) begin
      int sa, sb;
      bit ra, rb, st;
      logic [31:0] ea, eb;
      resolve(u, int'(id_rs), id_use_rs, sa, ra);
      resolve(u, int'(id_rt), id_use_rt, sb, rb);
      st = id_valid && !flush && (ra || rb);
      ea = (sa == 0) ? rf_a : slice(u, sa);
      eb = (sb == 0) ? rf_b : slice(u, sb);
      chk($sformatf("%s_u%0d_sel_a", tag, u), 32'(u == 0 ? fwd_sel_a0 : fwd_sel_a1), 32'(sa));
      chk($sformatf("%s_u%0d_sel_b", tag, u), 32'(u == 0 ? fwd_sel_b0 : fwd_sel_b1), 32'(sb));
      chk($sformatf("%s_u%0d_opnd_a", tag, u), u == 0 ? opnd_a0 : opnd_a1, ea);
      chk($sformatf("%s_u%0d_opnd_b", tag, u), u == 0 ? opnd_b0 : opnd_b1, eb);
      chk($sformatf("%s_u%0d_stall", tag, u), 32'(u == 0 ? stall0 : stall1), 32'(st));
      chk($sformatf("%s_u%0d_cnt", tag, u), 32'(u == 0 ? stall_cnt0 : stall_cnt1), 32'(mcnt[u]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wen, input int wa, input bit ld, input bit fl);
    id_valid = v;  id_rs = 5'(rs);  id_rt = 5'(rt);
    id_use_rs = urs;  id_use_rt = urt;
    id_wr_en = wen;  id_wr_addr = 5'(wa);  id_is_load = ld;  flush = fl;
  endtask

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; bit wen; int wa; bit ld; bit fl;
    int sa; int sb; bit st; int cnt;
  } vec_t;

  function automatic vec_t mk(bit v, int rs, int rt, bit urs, bit urt, bit wen, int wa,
                              bit ld, bit fl, int sa, int sb, bit st, int cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.wen = wen; r.wa = wa;
    r.ld = ld; r.fl = fl; r.sa = sa; r.sb = sb; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    int n0, n1;
    // Expected values below are for the DEPTH=3, LOAD_STAGE=2 instance.
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0);  // add r3
    tbl[1]  = mk(1, 3, 0, 1, 0, 1, 6, 0, 0,  1, 0, 0, 0);  // r3 back-to-back
    tbl[2]  = mk(1, 3, 0, 1, 0, 1, 4, 1, 0,  2, 0, 0, 0);  // lw r4, r3 from stage 2
    tbl[3]  = mk(1, 0, 4, 0, 1, 1, 7, 0, 0,  0, 0, 1, 0);  // load-use stall
    tbl[4]  = mk(1, 0, 4, 0, 1, 1, 7, 0, 0,  0, 2, 0, 1);  // held, load data forwarded
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 1);  // r5 (will be stage 3)
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 1);  // r5 again (stage 1)
    tbl[8]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);  // youngest wins
    tbl[9]  = mk(1, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 1);  // r0 write and reads
    tbl[10] = mk(1, 5, 0, 1, 1, 1, 8, 1, 0,  3, 0, 0, 1);  // r5 at stage 3, lw r8
    tbl[11] = mk(1, 0, 8, 0, 1, 1, 9, 0, 1,  0, 0, 0, 1);  // flush over load-use
    tbl[12] = mk(1, 9, 8, 1, 1, 0, 0, 0, 0,  0, 2, 0, 1);  // r9 never entered
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 1);  // lw r10
    tbl[14] = mk(0, 10, 0, 1, 0, 1, 11, 0, 0, 0, 0, 0, 1); // invalid ID: no stall
    tbl[15] = mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1);

    rst_n = 1'b0;
    set_id(1, 3, 4, 1, 1, 1, 3, 0, 0);
    rf_a = 32'hA000_0000;  rf_b = 32'hB000_0000;
    sres0 = {32'h0000_0011, 32'h1234_5678, 32'h0000_00AA};
    sres1 = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    model_reset();
    #12;
    check_now("reset");
    chk("reset_stall", 32'(stall0), 32'd0);
    chk("reset_opnd_a", opnd_a0, 32'hA000_0000);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ea, eb;
      set_id(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
             tbl[i].wen, tbl[i].wa, tbl[i].ld, tbl[i].fl);
      rf_a = 32'hA000_0000 + 32'(i);
      rf_b = 32'hB000_0000 + 32'(i);
      #2;
      ea = (tbl[i].sa == 0) ? rf_a : slice(0, tbl[i].sa);
      eb = (tbl[i].sb == 0) ? rf_b : slice(0, tbl[i].sb);
      chk($sformatf("vec%0d_sel_a", i), 32'(fwd_sel_a0), 32'(tbl[i].sa));
      chk($sformatf("vec%0d_sel_b", i), 32'(fwd_sel_b0), 32'(tbl[i].sb));
      chk($sformatf("vec%0d_opnd_a", i), opnd_a0, ea);
      chk($sformatf("vec%0d_opnd_b", i), opnd_b0, eb);
      chk($sformatf("vec%0d_stall", i), 32'(stall0), 32'(tbl[i].st));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt0), 32'(tbl[i].cnt));
      check_now($sformatf("vec%0d", i));
      tick();
    end

    // Async reset between edges with three valid writers in flight.
    for (int w = 1; w <= 3; w++) begin
      set_id(1, 0, 0, 0, 0, 1, w, 0, 0);
      #2;
      check_now("fill");
      tick();
    end
    set_id(1, 1, 3, 1, 1, 0, 0, 0, 0);
    #2;
    check_now("pre_rst");
    chk("pre_rst_sel_a", 32'(fwd_sel_a0), 32'd3);
    chk("pre_rst_sel_b", 32'(fwd_sel_b0), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("in_rst");
    chk("in_rst_sel_a", 32'(fwd_sel_a0), 32'd0);
    chk("in_rst_cnt", 32'(stall_cnt0), 32'd0);
    chk("in_rst_opnd_b", opnd_b0, rf_b);
    #1;
    rst_n = 1'b1;
    tick();
    #2;
    check_now("post_rst");
    chk("post_rst_sel_a", 32'(fwd_sel_a0), 32'd0);
    chk("post_rst_sel_b1", 32'(fwd_sel_b1), 32'd0);

    // Load-use length: 1 cycle for LOAD_STAGE=2, 3 cycles for LOAD_STAGE=4.
    set_id(1, 0, 0, 0, 0, 1, 4, 1, 0);
    #2;
    check_now("lu_lw");
    tick();
    set_id(1, 0, 4, 0, 1, 0, 0, 0, 0);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      check_now($sformatf("lu_c%0d", c));
      if (stall0) n0++;
      if (!stall1) break;
      n1++;
      tick();
    end
    chk("lu_len_d1", 32'(n1), 32'd3);
    chk("lu_len_d0", 32'(n0), 32'd1);
    chk("lu_sel_b_d1", 32'(fwd_sel_b1), 32'd4);
    chk("lu_opnd_b_d1", opnd_b1, 32'h4444_0004);
    chk("lu_cnt_d1", 32'(stall_cnt1), 32'd3);
    tick();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      rf_a = $urandom;
      rf_b = $urandom;
      sres0 = {$urandom, $urandom, $urandom};
      sres1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      #2;
      check_now($sformatf("rnd%0d", i));
      if (i == 250) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now("rnd_rst");
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
